lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store controller that sits between the single-cycle core's memory stage and the byte-addressed data memory (16-bit address, 4-bit per-byte write enable, registered write, combinational 32-bit read). It accepts one load or store request at a time over a valid/ready handshake and checks alignment and range. It generates the memory's byte-lane enables and write data, captures and sign- or zero-extends load data, and returns a registered response. It is the initiator end of the data-memory interface.

## Interface
- No parameters; address width 16 and data width 32 are fixed.
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  core request valid
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V width code: 000 b, 001 h, 010 w, 100 bu, 101 hu (bu/hu are loads only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response valid, held until accepted
- resp_ready  in  1  core accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  request rejected, no memory access performed
- mem_write  out  4  per-byte write enable to data memory (bit i writes byte addr+i)
- mem_addr  out  16  byte address to data memory
- mem_wdata  out  32  write data to data memory, lane i = bits 8i+7:8i
- mem_rdata  in  32  combinational read data from data memory

## Operation
- States: IDLE, WRITE, READ, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch the request and classify it:
  - error if req_addr[31:16]!=0, halfword with addr[0]=1, word with addr[1:0]!=0, store with funct3 in {100,101}, or funct3 in {011,110,111} -> RESP, resp_err=1, resp_rdata=0, mem_write never asserted
  - valid store -> WRITE; valid load -> READ
- WRITE (one cycle): mem_addr=latched addr[15:0]; mem_write = 0001 (b), 0011 (h), 1111 (w); mem_wdata=latched req_wdata unshifted, upper lanes don't-care but driven with latched data. Then -> RESP, resp_err=0, resp_rdata=0.
- READ (one cycle): mem_addr=latched addr, mem_write=0000; at the cycle-end edge, mem_rdata is extended and registered into resp_rdata: b -> sext [7:0]; h -> sext [15:0]; w -> [31:0]; bu/hu -> zext. Then -> RESP.
- RESP: resp_valid=1; resp_rdata and resp_err held stable; on resp_ready -> IDLE. Backpressure of any length is allowed.
- mem_write is 0000 in every state except WRITE.
- mem_addr and mem_wdata hold their last latched value outside accesses.

## Timing
- Handshake edge = edge 0. WRITE/READ occupy cycle 1. resp_valid rises after edge 1, so the response is seen in cycle 2. With resp_ready=1, the controller is back in IDLE and req_ready=1 in cycle 3.
- Error requests skip the access cycle: resp_valid in cycle 1.
- Store commits to memory at the edge ending WRITE. A subsequent load's READ is ≥2 cycles later and returns the new data.
- A resp_ready asserted while resp_valid=0 is ignored.
- Reset values: state IDLE, req_ready=1 after reset (0 while rst_n low), resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_wdata=0, mem_write=0000.
- mem_write is gated by rst_n combinationally: a store whose WRITE cycle coincides with rst_n=0 must not modify memory.
- Reset in any state discards the in-flight request; no response is produced.

## Structure
- Package lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum, byte-enable constants BE_B/BE_H/BE_W.
- One combinational sub-module, load_extend (mem_rdata, funct3 -> 32-bit extended data). All state lives in lsu_ctrl.

## Test plan
- Reset: rst_n=0 for 2 cycles with req_valid=1 -> req_ready=0, mem_write=0000, resp_valid=0. After release -> all outputs at reset values.
- sw 0xDEADBEEF @0x0010, then lw @0x0010 -> mem_write=1111 for exactly one cycle; load resp_rdata=0xDEADBEEF in cycle 2, resp_err=0.
- sb 0x80 @0x0021, then lb @0x0021 -> 0xFFFFFF80; lbu -> 0x00000080. mem_write=0001, mem_addr=0x0021.
- sh 0x8001 @0x0002, then lh -> 0xFFFF8001; lhu -> 0x00008001.
- lw @0x0003, sh @0x0005, sb @0x10000, store funct3=100 -> each gives resp_err=1 in cycle 1, resp_rdata=0, mem_write stays 0000, memory unchanged.
- Response held 5 cycles with resp_ready=0 -> resp_valid/resp_rdata stable, req_ready=0. rst_n=0 during WRITE of sw 0x12345678 @0x40 -> mem_write=0000, later lw @0x40 returns the old value.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, state type and request helpers for lsu_ctrl
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] BE_B = 4'b0001;
   localparam logic [3:0] BE_H = 4'b0011;
   localparam logic [3:0] BE_W = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_RESP  = 2'd3
   } lsu_state_e;

   // A rejected request never touches memory: bad width code, misaligned, out of range
   function automatic logic req_invalid(input logic we, input logic [2:0] f3,
                                        input logic [31:0] addr);
      logic bad;
      bad = (addr[31:16] != 16'h0000);
      case (f3)
         F3_B:    bad = bad;
         F3_BU:   bad = bad | we;
         F3_H:    bad = bad | addr[0];
         F3_HU:   bad = bad | addr[0] | we;
         F3_W:    bad = bad | (addr[1:0] != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [3:0] byte_enable(input logic [2:0] f3);
      logic [3:0] be;
      case (f3)
         F3_H, F3_HU: be = BE_H;
         F3_W:        be = BE_W;
         default:     be = BE_B;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - core request/response and data-memory signals of lsu_ctrl
interface lsu_ctrl_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   logic [3:0]  mem_write;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   // Controller side
   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready,
      output resp_valid, resp_rdata, resp_err,
      input  resp_ready,
      output mem_write, mem_addr, mem_wdata,
      input  mem_rdata
   );

   // Core plus data-memory side
   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready,
      input  resp_valid, resp_rdata, resp_err,
      output resp_ready,
      input  mem_write, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/lsu_ctrl_load_extend.sv
// rtl/lsu_ctrl_load_extend.sv - sign/zero extension of right-justified load data
module load_extend
   import lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   always_comb begin
      data_o = rdata_i;
      case (funct3_i)
         F3_B:    data_o = {{24{rdata_i[7]}}, rdata_i[7:0]};
         F3_H:    data_o = {{16{rdata_i[15]}}, rdata_i[15:0]};
         F3_BU:   data_o = {24'h000000, rdata_i[7:0]};
         F3_HU:   data_o = {16'h0000, rdata_i[15:0]};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - single-outstanding load/store controller in front of the data memory
module lsu_ctrl
   import lsu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   lsu_ctrl_if.slave  bus
);

   lsu_state_e  state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [31:0] ext_data;

   load_extend u_load_extend (
      .rdata_i  (bus.mem_rdata),
      .funct3_i (funct3_q),
      .data_o   (ext_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         addr_q   <= 16'h0000;
         wdata_q  <= 32'h0000_0000;
         funct3_q <= F3_B;
         rdata_q  <= 32'h0000_0000;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         funct3_q <= funct3_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      funct3_d = funct3_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               addr_d   = bus.req_addr[15:0];
               wdata_d  = bus.req_wdata;
               funct3_d = bus.req_funct3;
               rdata_d  = 32'h0000_0000;
               if (req_invalid(bus.req_we, bus.req_funct3, bus.req_addr)) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = bus.req_we ? ST_WRITE : ST_READ;
               end
            end
         end
         ST_WRITE: state_d = ST_RESP;
         ST_READ: begin
            rdata_d = ext_data;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Reset gates the write strobe directly so a store caught mid-access never commits
   assign bus.mem_write  = (rst_n && (state_q == ST_WRITE)) ? byte_enable(funct3_q) : 4'b0000;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = wdata_q;
   assign bus.req_ready  = rst_n && (state_q == ST_IDLE);
   assign bus.resp_valid = (state_q == ST_RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl with behavioural data memory
module tb_lsu_ctrl;

   typedef struct packed {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
      logic [3:0]  hold;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_bad = 0;

   lsu_ctrl_if bus();

   lsu_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Data memory: registered byte writes, combinational little-endian read
   logic [7:0] dmem [0:65535];
   logic       mem_ready = 1'b0;

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 65536; i++) dmem[i] <= 8'h00;
         mem_ready <= 1'b1;
      end else begin
         for (int i = 0; i < 4; i++)
            if (bus.mem_write[i]) dmem[bus.mem_addr + 16'(i)] <= bus.mem_wdata[8*i +: 8];
      end
   end

   assign bus.mem_rdata = {dmem[bus.mem_addr + 16'd3], dmem[bus.mem_addr + 16'd2],
                           dmem[bus.mem_addr + 16'd1], dmem[bus.mem_addr]};

   // Reference memory image as seen by the core
   logic [7:0] ref_mem [0:65535];

   function automatic int ref_size(input logic [2:0] f3);
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
   endfunction

   function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
      if (addr >= 32'h0001_0000) return 1'b1;
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
      if (we && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
      if (addr % ref_size(f3) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
      logic [31:0] v;
      int n;
      n = ref_size(f3);
      v = 0;
      for (int i = 0; i < n; i++) v = v + (32'(ref_mem[16'(addr) + 16'(i)]) << (8 * i));
      if (f3 == 3'd0 && v >= 32'h80) v = v + 32'hFFFF_FF00;
      if (f3 == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic do_req(input vec_t v);
      logic [3:0]  exp_be;
      logic [31:0] held;
      int n;
      n = ref_size(v.f3);
      exp_be = (n == 1) ? 4'b0001 : (n == 2) ? 4'b0011 : 4'b1111;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = v.we;
      bus.req_funct3 = v.f3;
      bus.req_addr   = v.addr;
      bus.req_wdata  = v.wdata;
      chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      if (v.exp_err) begin
         chk("err_resp_valid_c1", 32'(bus.resp_valid), 32'd1);
         chk("err_resp_err", 32'(bus.resp_err), 32'd1);
         chk("err_resp_rdata", bus.resp_rdata, 32'd0);
         chk("err_mem_write", 32'(bus.mem_write), 32'd0);
      end else begin
         chk("access_resp_valid_c1", 32'(bus.resp_valid), 32'd0);
         chk("access_mem_write", 32'(bus.mem_write), v.we ? 32'(exp_be) : 32'd0);
         chk("access_mem_addr", 32'(bus.mem_addr), 32'(v.addr[15:0]));
         if (v.we) chk("access_mem_wdata", bus.mem_wdata, v.wdata);
         @(posedge clk);
         #1;
         chk("resp_mem_write_off", 32'(bus.mem_write), 32'd0);
         chk("resp_valid_c2", 32'(bus.resp_valid), 32'd1);
         chk("resp_err", 32'(bus.resp_err), 32'd0);
         chk("resp_rdata", bus.resp_rdata, v.exp_rdata);
         if (v.we) for (int i = 0; i < n; i++) ref_mem[16'(v.addr) + 16'(i)] = v.wdata[8*i +: 8];
      end
      held = bus.resp_rdata;
      for (int c = 0; c < int'(v.hold); c++) begin
         @(posedge clk);
         #1;
         chk("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
         chk("hold_resp_rdata", bus.resp_rdata, held);
         chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.resp_ready = 1'b0;
      chk("after_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("after_req_ready", 32'(bus.req_ready), 32'd1);
   endtask

   vec_t tbl [17];
   vec_t rv;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
      tbl[0]  = '{1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 4'd0};
      tbl[1]  = '{1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 4'd5};
      tbl[2]  = '{1'b1, 3'd0, 32'h0000_0021, 32'h1122_3380, 1'b0, 32'h0000_0000, 4'd0};
      tbl[3]  = '{1'b0, 3'd0, 32'h0000_0021, 32'h0,         1'b0, 32'hFFFF_FF80, 4'd0};
      tbl[4]  = '{1'b0, 3'd4, 32'h0000_0021, 32'h0,         1'b0, 32'h0000_0080, 4'd1};
      tbl[5]  = '{1'b1, 3'd1, 32'h0000_0002, 32'h5555_8001, 1'b0, 32'h0000_0000, 4'd0};
      tbl[6]  = '{1'b0, 3'd1, 32'h0000_0002, 32'h0,         1'b0, 32'hFFFF_8001, 4'd0};
      tbl[7]  = '{1'b0, 3'd5, 32'h0000_0002, 32'h0,         1'b0, 32'h0000_8001, 4'd0};
      tbl[8]  = '{1'b0, 3'd2, 32'h0000_0003, 32'h0,         1'b1, 32'h0000_0000, 4'd0};
      tbl[9]  = '{1'b1, 3'd1, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 4'd2};
      tbl[10] = '{1'b1, 3'd0, 32'h0001_0000, 32'h0000_0055, 1'b1, 32'h0000_0000, 4'd0};
      tbl[11] = '{1'b1, 3'd4, 32'h0000_0020, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 4'd0};
      tbl[12] = '{1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 4'd0};
      tbl[13] = '{1'b0, 3'd2, 32'h0000_0000, 32'h0,         1'b0, 32'h8001_0000, 4'd0};
      tbl[14] = '{1'b0, 3'd2, 32'h0000_0020, 32'h0,         1'b0, 32'h0000_8000, 4'd0};
      tbl[15] = '{1'b0, 3'd3, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_0000, 4'd0};
      tbl[16] = '{1'b1, 3'd2, 32'h0000_0040, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, 4'd0};

      rst_n          = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_funct3 = 3'd2;
      bus.req_addr   = 32'h0000_0010;
      bus.req_wdata  = 32'hFFFF_FFFF;
      bus.resp_ready = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
         chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
         chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      end
      bus.req_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("post_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("post_rst_resp_err", 32'(bus.resp_err), 32'd0);
      chk("post_rst_resp_rdata", bus.resp_rdata, 32'd0);
      chk("post_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("post_rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("post_rst_mem_write", 32'(bus.mem_write), 32'd0);

      for (int i = 0; i < 17; i++) do_req(tbl[i]);

      // Reset lands on the WRITE cycle of a store: memory must keep the old word
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_funct3 = 3'd2;
      bus.req_addr   = 32'h0000_0040;
      bus.req_wdata  = 32'h1234_5678;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      chk("wr_before_rst_mem_write", 32'(bus.mem_write), 32'hF);
      rst_n = 1'b0;
      #1;
      chk("wr_rst_mem_write", 32'(bus.mem_write), 32'd0);
      @(posedge clk);
      #1;
      chk("wr_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("wr_rst_req_ready", 32'(bus.req_ready), 32'd1);
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("wr_rst_no_resp", 32'(bus.resp_valid), 32'd0);
      end
      do_req('{1'b0, 3'd2, 32'h0000_0040, 32'h0, 1'b0, 32'hCAFE_F00D, 4'd0});

      for (int k = 0; k < 80; k++) begin
         rv.we    = 1'($urandom_range(0, 1));
         rv.f3    = 3'($urandom_range(0, 7));
         rv.addr  = 32'($urandom_range(0, 127));
         if ($urandom_range(0, 11) == 0) rv.addr = rv.addr + 32'h0001_0000;
         rv.wdata = $urandom;
         rv.hold  = 4'($urandom_range(0, 3));
         rv.exp_err   = ref_err(rv.we, rv.f3, rv.addr);
         rv.exp_rdata = (rv.exp_err || rv.we) ? 32'd0 : ref_load(rv.f3, rv.addr);
         do_req(rv);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
